// File: rtl/dma_cfg_slave_pkg.sv
// Shared definitions for the DMA configuration slave.
// Register offsets, CTRL/STATUS bit positions, AXI codes, FSM states.
package dma_cfg_slave_pkg;

    // Register index = addr[4:2]
    localparam logic [2:0] IDX_SRC  = 3'd0;
    localparam logic [2:0] IDX_DST  = 3'd1;
    localparam logic [2:0] IDX_QTY  = 3'd2;
    localparam logic [2:0] IDX_CTRL = 3'd3;
    localparam logic [2:0] IDX_STAT = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_AW, W_W, W_B} w_state_e;
    typedef enum logic       {R_AR, R_R}      r_state_e;

endpackage

// File: rtl/dma_cfg_slave_if.sv
// AXI4 slave-side bus bundle for the DMA configuration slave.
// master: CPU/interconnect side; slave: dma_cfg_slave side.
interface dma_cfg_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8
);
    logic [IDS_W-1:0]    awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [IDS_W-1:0]    bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [IDS_W-1:0]    arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [IDS_W-1:0]    rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/dma_cfg_regs.sv
// Register array: SRC/DST/QTY, CTRL (START/IE), STATUS (BUSY/DONE).
// Ports: we/widx/wdata/wstrb write, ridx/rdata read, dma_fin_i in, dma_en/regs/irq out.
module dma_cfg_regs
    import dma_cfg_slave_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [2:0]          widx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [2:0]          ridx_i,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                dma_fin_i,
    output logic                dma_en_o,
    output logic [DATA_W-1:0]   src_o,
    output logic [DATA_W-1:0]   dst_o,
    output logic [DATA_W-1:0]   qty_o,
    output logic                irq_o
);
    logic [DATA_W-1:0] src_q, dst_q, qty_q;
    logic ie_q, busy_q, done_q, en_q;
    logic ctrl_we, stat_we, start;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0]   old,
        input logic [DATA_W-1:0]   wd,
        input logic [DATA_W/8-1:0] st
    );
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < DATA_W/8; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign ctrl_we = we_i && widx_i == IDX_CTRL && wstrb_i[0];
    assign stat_we = we_i && widx_i == IDX_STAT && wstrb_i[0];
    // BUSY is the registered value, so a START racing dma_fin_i is dropped.
    assign start   = ctrl_we && wdata_i[CTRL_START] && !busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            qty_q  <= '0;
            ie_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            en_q <= start;
            if (we_i && widx_i == IDX_SRC) src_q <= merge(src_q, wdata_i, wstrb_i);
            if (we_i && widx_i == IDX_DST) dst_q <= merge(dst_q, wdata_i, wstrb_i);
            if (we_i && widx_i == IDX_QTY) qty_q <= merge(qty_q, wdata_i, wstrb_i);
            if (ctrl_we) ie_q <= wdata_i[CTRL_IE];
            // Completion has priority over a concurrent DONE clear.
            if (dma_fin_i) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else if (start) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else if (stat_we && wdata_i[STAT_DONE]) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (ridx_i)
            IDX_SRC:  rdata_o = src_q;
            IDX_DST:  rdata_o = dst_q;
            IDX_QTY:  rdata_o = qty_q;
            IDX_CTRL: rdata_o[CTRL_IE] = ie_q;
            IDX_STAT: begin
                rdata_o[STAT_BUSY] = busy_q;
                rdata_o[STAT_DONE] = done_q;
            end
            default: rdata_o = '0;
        endcase
    end

    assign dma_en_o = en_q;
    assign src_o    = src_q;
    assign dst_o    = dst_q;
    assign qty_o    = qty_q;
    assign irq_o    = done_q & ie_q;
endmodule

// File: rtl/dma_cfg_slave.sv
// AXI4 slave that programs and launches the DMA engine.
// Ports: clk/rst_n, bus (AXI slave modport), dma_en_o/src/dst/qty out, dma_fin_i in, dma_irq_o.
module dma_cfg_slave
    import dma_cfg_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dma_cfg_slave_if.slave    bus,
    output logic              dma_en_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] data_qty_o,
    input  logic              dma_fin_i,
    output logic              dma_irq_o
);
    w_state_e          w_state_q;
    logic              awready_q, wready_q, bvalid_q, wlen_err_q;
    logic [IDS_W-1:0]  bid_q;
    logic [1:0]        bresp_q;
    logic [2:0]        widx_q;

    r_state_e          r_state_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [IDS_W-1:0]  rid_q;
    logic [DATA_W-1:0] rdata_q, reg_rdata;
    logic [1:0]        rresp_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, reg_we;
    logic [DATA_W-1:0] src, dst;
    logic unused_ok;

    assign aw_hs  = bus.awvalid & awready_q;
    assign w_hs   = bus.wvalid & wready_q;
    assign b_hs   = bus.bready & bvalid_q;
    assign ar_hs  = bus.arvalid & arready_q;
    assign r_hs   = bus.rready & rvalid_q;
    assign reg_we = w_hs & ~wlen_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_AW;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            widx_q     <= '0;
            wlen_err_q <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_AW: begin
                    awready_q <= ~aw_hs;
                    if (aw_hs) begin
                        bid_q      <= bus.awid;
                        widx_q     <= bus.awaddr[4:2];
                        wlen_err_q <= bus.awlen != 8'd0;
                        wready_q   <= 1'b1;
                        w_state_q  <= W_W;
                    end
                end
                W_W: begin
                    // Bursts are drained beat by beat; only wlast ends them.
                    if (w_hs && (!wlen_err_q || bus.wlast)) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wlen_err_q ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_B;
                    end
                end
                W_B: begin
                    if (b_hs) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_AW;
                    end
                end
                default: w_state_q <= W_AW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_AR;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_AR: begin
                    arready_q <= ~ar_hs;
                    if (ar_hs) begin
                        rid_q     <= bus.arid;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= 1'b1;
                        r_state_q <= R_R;
                        if (bus.arlen != 8'd0) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            rdata_q <= reg_rdata;
                            rresp_q <= RESP_OKAY;
                        end
                    end
                end
                R_R: begin
                    if (r_hs) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_AR;
                    end
                end
                default: r_state_q <= R_AR;
            endcase
        end
    end

    dma_cfg_regs #(.DATA_W(DATA_W)) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (reg_we),
        .widx_i    (widx_q),
        .wdata_i   (bus.wdata),
        .wstrb_i   (bus.wstrb),
        .ridx_i    (bus.araddr[4:2]),
        .rdata_o   (reg_rdata),
        .dma_fin_i (dma_fin_i),
        .dma_en_o  (dma_en_o),
        .src_o     (src),
        .dst_o     (dst),
        .qty_o     (data_qty_o),
        .irq_o     (dma_irq_o)
    );

    assign src_addr_o  = ADDR_W'(src);
    assign dst_addr_o  = ADDR_W'(dst);

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // Size/burst type are not needed for single-word registers.
    assign unused_ok = ^{bus.awsize, bus.awburst, bus.arsize, bus.arburst,
                         bus.awaddr[ADDR_W-1:5], bus.awaddr[1:0],
                         bus.araddr[ADDR_W-1:5], bus.araddr[1:0]};
endmodule

// File: tb/tb_dma_cfg_slave.sv
// Randomized self-checking bench for dma_cfg_slave.
// Compares AXI responses and DMA control outputs against a register-level model.
module tb_dma_cfg_slave;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_en, dma_fin, dma_irq;
    logic [31:0] src_o, dst_o, qty_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_src, m_dst, m_qty;
    bit          m_ie, m_busy, m_done;

    dma_cfg_slave_if #(.ADDR_W(32), .DATA_W(32), .IDS_W(8)) bus ();

    dma_cfg_slave #(.ADDR_W(32), .DATA_W(32), .IDS_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dma_en_o   (dma_en),
        .src_addr_o (src_o),
        .dst_addr_o (dst_o),
        .data_qty_o (qty_o),
        .dma_fin_i  (dma_fin),
        .dma_irq_o  (dma_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_src = 0; m_dst = 0; m_qty = 0;
        m_ie = 0; m_busy = 0; m_done = 0;
    endfunction

    // Returns 1 when the write launches the DMA.
    function automatic bit m_write(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb, input logic [7:0] len);
        logic [31:0] mask;
        bit st;
        st = 0;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (len != 0) return 0;
        case (addr[4:2])
            3'd0: m_src = (m_src & ~mask) | (data & mask);
            3'd1: m_dst = (m_dst & ~mask) | (data & mask);
            3'd2: m_qty = (m_qty & ~mask) | (data & mask);
            3'd3: if (strb[0]) begin
                m_ie = data[1];
                if (data[0] && !m_busy) begin
                    st = 1; m_busy = 1; m_done = 0;
                end
            end
            3'd4: if (strb[0] && data[1]) m_done = 0;
            default: ;
        endcase
        return st;
    endfunction

    function automatic void m_fin();
        m_busy = 0;
        m_done = 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr, input logic [7:0] len);
        if (len != 0) return 0;
        case (addr[4:2])
            3'd0: return m_src;
            3'd1: return m_dst;
            3'd2: return m_qty;
            3'd3: return {30'b0, m_ie, 1'b0};
            3'd4: return {30'b0, m_done, m_busy};
            default: return 0;
        endcase
    endfunction

    task automatic chk_ports();
        chk("src_port", src_o, m_src);
        chk("dst_port", dst_o, m_dst);
        chk("qty_port", qty_o, m_qty);
        chk("irq", 32'(dma_irq), 32'(m_ie & m_done));
    endtask

    // All bus tasks start and end one time unit after a rising edge.
    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [7:0] len,
                          input logic [7:0] id, input int bdly, input bit fin_w);
        int n;
        bit st;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
        chk("awready", 32'(bus.awready), 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.wdata = data; bus.wstrb = strb;
            bus.wlast = (b == int'(len)); bus.wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
            chk("wready", 32'(bus.wready), 1);
            if (fin_w && b == int'(len)) dma_fin = 1'b1;
            @(posedge clk); #1;
            dma_fin = 1'b0;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        st = m_write(addr, data, strb, len);
        if (fin_w) m_fin();
        @(negedge clk);
        chk("bvalid_lat", 32'(bus.bvalid), 1);
        chk("dma_en", 32'(dma_en), 32'(st));
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bus.bvalid), 1);
            chk("aw_blocked", 32'(bus.awready), 0);
            if (i == 0) chk("dma_en_off", 32'(dma_en), 0);
        end
        bus.bready = 1'b1;
        chk("bid", 32'(bus.bid), 32'(id));
        chk("bresp", 32'(bus.bresp), (len != 0) ? 32'd2 : 32'd0);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("bvalid_clr", 32'(bus.bvalid), 0);
        chk("dma_en_1cyc", 32'(dma_en), 0);
    endtask

    task automatic axi_rd(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input int rdly);
        int n;
        logic [31:0] exp;
        exp = m_read(addr, len);
        bus.arid = id; bus.araddr = addr; bus.arlen = len;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
        chk("arready", 32'(bus.arready), 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_lat", 32'(bus.rvalid), 1);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(bus.rvalid), 1);
            chk("ar_blocked", 32'(bus.arready), 0);
        end
        bus.rready = 1'b1;
        chk("rid", 32'(bus.rid), 32'(id));
        chk("rdata", bus.rdata, exp);
        chk("rresp", 32'(bus.rresp), (len != 0) ? 32'd2 : 32'd0);
        chk("rlast", 32'(bus.rlast), 1);
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk("rvalid_clr", 32'(bus.rvalid), 0);
    endtask

    task automatic fin_pulse();
        dma_fin = 1'b1;
        @(posedge clk); #1;
        dma_fin = 1'b0;
        m_fin();
    endtask

    initial begin
        logic [31:0] old, d, a;
        logic [7:0]  ln;
        int op;
        bit st;

        rst_n = 1'b0; dma_fin = 1'b0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awburst = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.wlast = 0; bus.wvalid = 0; bus.bready = 0; bus.arid = 0;
        bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.arvalid = 0; bus.rready = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_bvalid", 32'(bus.bvalid), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_bresp", 32'(bus.bresp), 0);
        chk("rst_rresp", 32'(bus.rresp), 0);
        chk("rst_dma_en", 32'(dma_en), 0);
        chk_ports();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Program and launch
        axi_wr(32'h00, 32'h0001_0000, 4'hF, 0, 8'h01, 0, 0);
        axi_wr(32'h04, 32'h2000_0000, 4'hF, 0, 8'h02, 0, 0);
        axi_wr(32'h08, 32'h0000_0300, 4'hF, 0, 8'h03, 0, 0);
        axi_wr(32'h0C, 32'h3, 4'hF, 0, 8'h04, 0, 0);
        chk_ports();
        axi_rd(32'h10, 0, 8'h11, 0);

        // START while busy is ignored; IE rewritten to 0 by this write
        axi_wr(32'h0C, 32'h1, 4'hF, 0, 8'h05, 0, 0);
        fin_pulse();
        axi_rd(32'h10, 0, 8'h12, 0);
        chk_ports();
        axi_wr(32'h0C, 32'h2, 4'hF, 0, 8'h06, 0, 0);
        chk_ports();

        // DONE clear racing completion: completion wins
        axi_wr(32'h0C, 32'h3, 4'hF, 0, 8'h07, 0, 0);
        axi_wr(32'h10, 32'h2, 4'hF, 0, 8'h08, 0, 1);
        axi_rd(32'h10, 0, 8'h13, 0);
        chk_ports();
        axi_wr(32'h10, 32'h2, 4'hF, 0, 8'h09, 0, 0);
        axi_rd(32'h10, 0, 8'h14, 0);
        chk_ports();

        // Bursts are rejected
        old = m_src;
        axi_wr(32'h00, 32'hDEAD_BEEF, 4'hF, 3, 8'h0A, 0, 0);
        chk("burst_src", src_o, old);
        axi_rd(32'h00, 1, 8'h15, 0);

        // Back-pressure
        axi_wr(32'h04, 32'h1234_5678, 4'hF, 0, 8'hA5, 5, 0);
        axi_rd(32'h04, 0, 8'h5A, 5);
        chk_ports();

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            a  = {27'b0, 3'($urandom_range(0, 7)), 2'b00};
            ln = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            if (op <= 3) begin
                axi_wr(a, $urandom, 4'($urandom), ln, 8'($urandom),
                       $urandom_range(0, 2), 0);
            end else if (op <= 6) begin
                axi_rd(a, ln, 8'($urandom), $urandom_range(0, 2));
            end else if (op == 7) begin
                if (m_busy) fin_pulse();
            end else if (op == 8) begin
                d = {30'b0, 1'($urandom), 1'b1};
                axi_wr(32'h0C, d, 4'hF, 0, 8'($urandom), 0, 0);
            end else begin
                axi_rd(32'h10, 0, 8'($urandom), 0);
            end
            chk_ports();
        end

        // Reset in the cycle after a START write
        if (m_busy) fin_pulse();
        bus.awid = 8'h3C; bus.awaddr = 32'h0C; bus.awlen = 0; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        st = m_write(32'h0C, 32'h1, 4'hF, 0);
        chk("pre_rst_en", 32'(dma_en), 32'(st));
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst2_dma_en", 32'(dma_en), 0);
        chk("rst2_bvalid", 32'(bus.bvalid), 0);
        chk("rst2_wready", 32'(bus.wready), 0);
        chk("rst2_awready", 32'(bus.awready), 0);
        chk_ports();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst2_en_after", 32'(dma_en), 0);
        axi_rd(32'h10, 0, 8'h77, 0);
        chk_ports();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
